fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch controller for the five-stage core. Owns the program counter and drives the instruction ROM's byte-address input. It registers the returned word into the IF/ID pipeline register. It also handles hazard stalls, branch/jump redirects and end-of-program halt, so the ROM is sequenced by exactly one agent.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)
ROM_WORDS, 30, number of valid 32-bit words in the ROM; fetch beyond this halts

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rom_pc  out  32  byte address to ROM, combinational from pc register
rom_instr  in  32  instruction word from ROM, valid in the same cycle as rom_pc
stall  in  1  hazard unit request to hold IF and IF/ID
redirect_valid  in  1  branch/jump taken, from EX
redirect_pc  in  32  target byte address for the redirect
id_valid  out  1  IF/ID register holds a real instruction
id_pc  out  32  byte address of the instruction in IF/ID
id_instr  out  32  instruction in IF/ID; 32'h00000013 (nop) when id_valid=0
halted  out  1  fetch stopped at end of ROM
fetch_count  out  32  number of instructions accepted into IF/ID since reset

Behaviour:
- Reset (async, any time, including mid-redirect or in HALT):
  - pc=RESET_PC, state=BOOT, id_valid=0, id_pc=0, id_instr=32'h00000013, halted=0, fetch_count=0.
- rom_pc = pc at all times. The ROM read is combinational, so IF takes one cycle from pc to the IF/ID register.
- In-range test: (pc>>2) < ROM_WORDS.
- State BOOT (one cycle after reset deasserts):
  - No fetch; IF/ID holds the bubble.
  - Next state is FETCH.
  - A redirect in BOOT loads pc (rule below) and still goes to FETCH.
- State FETCH, priority order each cycle:
  1. redirect_valid=1:
     - pc <= redirect_pc & ~32'h3 (low bits cleared).
     - IF/ID loads a bubble (id_valid=0, id_instr=nop); the wrong-path word currently in IF is discarded.
     - fetch_count unchanged.
     - Redirect wins over stall.
  2. stall=1: pc, IF/ID and fetch_count hold their values.
  3. pc in range:
     - id_valid<=1, id_pc<=pc, id_instr<=rom_instr.
     - pc<=pc+4.
     - fetch_count<=fetch_count+1 (wraps modulo 2^32).
  4. pc out of range:
     - IF/ID loads a bubble; state<=HALT; pc unchanged.
- State HALT:
  - halted=1 (registered, asserted from the first HALT cycle).
  - IF/ID loads a bubble every cycle that stall=0 and holds while stall=1, so an instruction stalled in IF/ID is never lost.
  - pc frozen.
  - redirect_valid=1 applies the redirect rule above, clears halted and returns to FETCH. The next cycle re-evaluates the range.
- pc arithmetic is 32-bit. pc+4 wrapping past 32'hFFFF_FFFC yields 0, which is in range. No special handling beyond that.
- RESET_PC or a redirect target out of range → halts after exactly one bubble cycle. The ROM is never indexed out of range into IF/ID.
- Simultaneous stall and redirect in the same cycle → redirect taken, bubble inserted.
- All outputs except rom_pc are registered.

Test Plan:
- Straight-line fetch:
  - Setup: RESET_PC=0, ROM loaded with words 0..29, no stall or redirect.
  - Sequence: after reset, the BOOT cycle shows id_valid=0. Then id_pc steps 0,4,8,… each cycle, with id_instr matching ROM word pc>>2.
  - End: the cycle after id_pc=116, halted=1 and id_valid=0. fetch_count=30.
- Stall:
  - Stimulus: assert stall for 3 cycles while id_pc=8.
  - Required: id_pc, id_instr and rom_pc hold, with rom_pc=12. After release, id_pc=12 on the next edge. fetch_count increments exactly once per accepted word.
- Redirect:
  - Stimulus: at id_pc=16, assert redirect_valid with redirect_pc=32'h6.
  - Required: the next cycle gives id_valid=0 and rom_pc=4. The following cycle gives id_pc=4. This checks bubble insertion and low-bit clearing.
- Redirect with stall:
  - Stimulus: stall=1 and redirect_valid=1 (target 40) in the same cycle.
  - Required: redirect taken, id_valid=0, next rom_pc=40.
- Halt and recovery:
  - Stimulus: run to HALT, then hold 5 cycles.
  - Required: rom_pc stays 120, halted=1, id_instr=32'h00000013. A redirect to 0 clears halted and fetch resumes at id_pc=0.
- Async reset mid-run:
  - Stimulus: assert rst between clock edges while pc=52.
  - Required: outputs go to reset values immediately, without waiting for a clock edge. After deassert, the BOOT cycle comes first, then id_pc=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch controller for the five-stage core. It owns the program
// counter, drives the instruction ROM's byte address, and registers the
// returned word into the IF/ID pipeline register. It also applies hazard
// stalls, branch/jump redirects and the end-of-program halt, so exactly one
// agent sequences the ROM.
//
// Ports:
//   clk            in   1   core clock, rising-edge state updates
//   rst            in   1   asynchronous, active-high reset
//   rom_pc         out  32  byte address to ROM (combinational from pc)
//   rom_instr      in   32  ROM word for rom_pc, valid in the same cycle
//   stall          in   1   hold IF and IF/ID
//   redirect_valid in   1   taken branch/jump from EX
//   redirect_pc    in   32  redirect target byte address
//   id_valid       out  1   IF/ID holds a real instruction
//   id_pc          out  32  byte address of the IF/ID instruction
//   id_instr       out  32  IF/ID instruction, nop when id_valid=0
//   halted         out  1   fetch stopped at end of ROM
//   fetch_count    out  32  instructions accepted into IF/ID since reset
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 30
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_pc,
    input  logic [31:0] rom_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] ROM_WORDS_W = 32'(ROM_WORDS);
    localparam logic [31:0] ALIGN_MASK  = ~32'h0000_0003;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic        id_valid_q,    id_valid_d;
    logic [31:0] id_pc_q,       id_pc_d;
    logic [31:0] id_instr_q,    id_instr_d;
    logic        halted_q,      halted_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    // Word index of a byte address must fall inside the populated ROM.
    function automatic logic pc_in_range(input logic [31:0] pc);
        return ((pc >> 2) < ROM_WORDS_W);
    endfunction

    // Redirect targets are forced to word alignment.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return (pc & ALIGN_MASK);
    endfunction

    // ROM address comes straight from the pc register.
    assign rom_pc = pc_q;

    // Next-state, pc, IF/ID and counter logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_pc_d       = id_pc_q;
        id_instr_d    = id_instr_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_BOOT: begin
                // No fetch in the boot cycle; a redirect still updates pc.
                state_d    = ST_FETCH;
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
                halted_d   = 1'b0;
                if (redirect_valid) begin
                    pc_d = align_pc(redirect_pc);
                end else begin
                    pc_d = pc_q;
                end
            end

            ST_FETCH: begin
                if (redirect_valid) begin
                    // Discard the wrong-path word currently in IF.
                    pc_d       = align_pc(redirect_pc);
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (pc_in_range(pc_q)) begin
                    id_valid_d    = 1'b1;
                    id_pc_d       = pc_q;
                    id_instr_d    = rom_instr;
                    pc_d          = pc_q + 32'd4;
                    fetch_count_d = fetch_count_q + 32'd1;
                end else begin
                    // Never latch an out-of-range ROM word.
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                    state_d    = ST_HALT;
                    halted_d   = 1'b1;
                end
            end

            ST_HALT: begin
                if (redirect_valid) begin
                    pc_d       = align_pc(redirect_pc);
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                    halted_d   = 1'b0;
                    state_d    = ST_FETCH;
                end else if (stall) begin
                    // Keep a stalled instruction in IF/ID until released.
                    pc_d = pc_q;
                end else begin
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                end
            end

            default: begin
                state_d    = ST_BOOT;
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
                halted_d   = 1'b0;
            end
        endcase
    end

    // State, pc, IF/ID and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_pc_q       <= 32'h0000_0000;
            id_instr_q    <= NOP_INSTR;
            halted_q      <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            id_instr_q    <= id_instr_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_instr    = id_instr_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl: straight-line fetch to halt, halt hold and
// recovery, stall, redirect, redirect+stall, async reset mid-run, and an
// out-of-range redirect target.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] rom_pc;
    logic [31:0] rom_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        halted;
    logic [31:0] fetch_count;

    int checks_cnt;
    int fail_cnt;

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .ROM_WORDS(30)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_pc        (rom_pc),
        .rom_instr     (rom_instr),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    // ROM word n is an addi encoding carrying n in its immediate field.
    function automatic logic [31:0] rom_word(input logic [31:0] n);
        return (32'h0000_0093 | (n << 20));
    endfunction

    // 30-word ROM model; out-of-range addresses return a poison pattern.
    always_comb begin
        if ((rom_pc >> 2) < 32'd30) begin
            rom_instr = rom_word(rom_pc >> 2);
        end else begin
            rom_instr = 32'hDEAD_BEEF;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_cnt     = 0;
        fail_cnt       = 0;
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset values, before any clock edge.
        #1 rst = 1'b1;
        #2;
        check_eq("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("rst_id_pc", id_pc, 32'd0);
        check_eq("rst_id_instr", id_instr, NOP);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_fetch_count", fetch_count, 32'd0);
        check_eq("rst_rom_pc", rom_pc, 32'd0);

        @(posedge clk);
        @(posedge clk);
        #7 rst = 1'b0;

        // BOOT cycle: no fetch.
        step();
        check_eq("boot_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("boot_rom_pc", rom_pc, 32'd0);

        // Straight-line fetch of all 30 words.
        for (int i = 0; i < 30; i++) begin
            step();
            check_eq("seq_id_valid", {31'd0, id_valid}, 32'd1);
            check_eq("seq_id_pc", id_pc, 32'(i * 4));
            check_eq("seq_id_instr", id_instr, rom_word(32'(i)));
            check_eq("seq_fetch_count", fetch_count, 32'(i + 1));
        end

        // End of ROM.
        step();
        check_eq("end_halted", {31'd0, halted}, 32'd1);
        check_eq("end_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("end_fetch_count", fetch_count, 32'd30);
        check_eq("end_rom_pc", rom_pc, 32'd120);

        // Hold in HALT.
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("halt_rom_pc", rom_pc, 32'd120);
            check_eq("halt_halted", {31'd0, halted}, 32'd1);
            check_eq("halt_id_instr", id_instr, NOP);
        end

        // Recovery by redirect to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        check_eq("rec_halted", {31'd0, halted}, 32'd0);
        check_eq("rec_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("rec_rom_pc", rom_pc, 32'd0);
        step();
        check_eq("rec_id_pc0", id_pc, 32'd0);
        check_eq("rec_id_valid1", {31'd1 & 31'd0, id_valid}, 32'd1);
        check_eq("rec_fetch_count", fetch_count, 32'd31);
        step();
        check_eq("rec_id_pc4", id_pc, 32'd4);
        step();
        check_eq("pre_stall_id_pc", id_pc, 32'd8);
        check_eq("pre_stall_rom_pc", rom_pc, 32'd12);

        // Stall for three cycles at id_pc=8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_id_pc", id_pc, 32'd8);
            check_eq("stall_id_instr", id_instr, rom_word(32'd2));
            check_eq("stall_rom_pc", rom_pc, 32'd12);
            check_eq("stall_fetch_count", fetch_count, 32'd33);
        end
        stall = 1'b0;
        step();
        check_eq("post_stall_id_pc", id_pc, 32'd12);
        check_eq("post_stall_fetch_count", fetch_count, 32'd34);
        step();
        check_eq("pre_redir_id_pc", id_pc, 32'd16);

        // Redirect with unaligned target 6.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0006;
        step();
        redirect_valid = 1'b0;
        check_eq("redir_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("redir_id_instr", id_instr, NOP);
        check_eq("redir_rom_pc", rom_pc, 32'd4);
        check_eq("redir_fetch_count", fetch_count, 32'd35);
        step();
        check_eq("redir_id_pc", id_pc, 32'd4);
        check_eq("redir_id_instr1", id_instr, rom_word(32'd1));
        check_eq("redir_fetch_count1", fetch_count, 32'd36);

        // Redirect and stall together: redirect wins.
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd40;
        step();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        check_eq("rs_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("rs_rom_pc", rom_pc, 32'd40);
        check_eq("rs_fetch_count", fetch_count, 32'd36);
        step();
        check_eq("rs_id_pc", id_pc, 32'd40);
        check_eq("rs_id_instr", id_instr, rom_word(32'd10));
        check_eq("rs_fetch_count1", fetch_count, 32'd37);
        step();
        step();
        check_eq("pre_rst_rom_pc", rom_pc, 32'd52);

        // Async reset between edges.
        #3 rst = 1'b1;
        #1;
        check_eq("arst_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("arst_id_pc", id_pc, 32'd0);
        check_eq("arst_id_instr", id_instr, NOP);
        check_eq("arst_fetch_count", fetch_count, 32'd0);
        check_eq("arst_rom_pc", rom_pc, 32'd0);
        #2 rst = 1'b0;
        step();
        check_eq("arst_boot_id_valid", {31'd0, id_valid}, 32'd0);
        step();
        check_eq("arst_first_id_valid", {31'd0, id_valid}, 32'd1);
        check_eq("arst_first_id_pc", id_pc, 32'd0);
        check_eq("arst_first_fetch_count", fetch_count, 32'd1);

        // Redirect to an out-of-range target halts after one bubble.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        check_eq("oor_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("oor_halted0", {31'd0, halted}, 32'd0);
        check_eq("oor_rom_pc", rom_pc, 32'h200);
        step();
        check_eq("oor_halted1", {31'd0, halted}, 32'd1);
        check_eq("oor_id_instr", id_instr, NOP);
        check_eq("oor_fetch_count", fetch_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
